// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing shared by the timing generator, colour generator and benches.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  // Half-open window test [lo, hi) on a raster counter.
  function automatic logic in_window(input cnt_t v, input int lo, input int hi);
    return (v >= cnt_t'(lo)) && (v < cnt_t'(hi));
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth clk shift register with a per-bit reset value; DEPTH=0 is a wire.
module vga_sync_delay #(
  parameter int             W       = 3,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel strobe, x/y/bright for the colour generator and
// DAC-side sync/blank delayed to line up with the colour generator's registered RGB.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int CLK_DIV    = 2,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pix_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             bright,
  output logic             frame_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             blank_n,
  output logic             sync_n,
  output logic             vga_clk
);

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  logic [DIV_W-1:0] div_cnt;
  cnt_t             h_cnt;
  cnt_t             v_cnt;
  logic             hs_dec;
  logic             vs_dec;

  assign pix_en = (div_cnt == DIV_LAST);
  assign sync_n = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // div_cnt==0 marks the single clk right after a counter update, so the tick
  // fires once per frame and lands in the same clk that y takes V_ACTIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      bright     <= 1'b0;
      hs_dec     <= SYNC_OFF;
      vs_dec     <= SYNC_OFF;
      frame_tick <= 1'b0;
      vga_clk    <= 1'b0;
    end else begin
      x          <= h_cnt;
      y          <= v_cnt;
      bright     <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs_dec     <= in_window(h_cnt, HS_START, HS_END) ? SYNC_ON : SYNC_OFF;
      vs_dec     <= in_window(v_cnt, VS_START, VS_END) ? SYNC_ON : SYNC_OFF;
      frame_tick <= (div_cnt == '0) && (h_cnt == '0) && (v_cnt == V_ACT);
      vga_clk    <= (div_cnt >= DIV_HALF);
    end
  end

  vga_sync_delay #(
    .W       (3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL ({SYNC_OFF, SYNC_OFF, 1'b0})
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({hs_dec, vs_dec, bright}),
    .q     ({hsync, vsync, blank_n})
  );

endmodule
